// File: rtl/memory_controller.sv
// Time-multiplexes one synchronous-read data-memory port across N_CORES cores, one core slot per cycle.
// Latency: MReady low for N_CORES+1 cycles per batch. New requests are ignored (not queued) while busy.
module memory_controller #(
    parameter int N_CORES = 4,
    parameter int DW      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MRead,
    input  logic                  MWrite,
    output logic                  MReady,
    input  logic [N_CORES-1:0]    en,
    input  logic [N_CORES*DW-1:0] addr,
    input  logic [N_CORES*DW-1:0] data,
    output logic [N_CORES*DW-1:0] q,
    output logic [DW-1:0]         data_to_mem,
    output logic [DW-1:0]         addr_mem,
    input  logic [DW-1:0]         data_from_mem,
    output logic                  wren
);

    localparam int              IW       = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam logic [IW-1:0]   LAST_IDX = IW'(N_CORES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FINISH = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    state_t               state;
    op_t                  op;
    logic [IW-1:0]        idx;
    logic [N_CORES-1:0]   en_l;
    logic                 ready_r;

    logic                 cap_vld;
    logic [IW-1:0]        cap_idx;
    logic [N_CORES*DW-1:0] q_r;

    // Batch sequencer: every core gets exactly one slot, enabled or not,
    // so batch latency never depends on the participation mask.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            op      <= OP_READ;
            idx     <= '0;
            en_l    <= '0;
            ready_r <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (MRead || MWrite) begin
                        op      <= MWrite ? OP_WRITE : OP_READ;
                        en_l    <= en;
                        idx     <= '0;
                        ready_r <= 1'b0;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (idx == LAST_IDX) begin
                        state <= FINISH;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                FINISH: begin
                    idx     <= '0;
                    ready_r <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Memory-side drive; addr and data are taken live from the core whose slot it is.
    always_comb begin
        addr_mem    = '0;
        data_to_mem = '0;
        wren        = 1'b0;
        if (state == ACCESS) begin
            addr_mem    = addr[idx*DW +: DW];
            data_to_mem = data[idx*DW +: DW];
            wren        = (op == OP_WRITE) && en_l[idx];
        end
    end

    // Read data returns one cycle after the address, so remember which slot
    // issued a read and steer the returning word into that core's q next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_vld <= 1'b0;
            cap_idx <= '0;
            q_r     <= '0;
        end else begin
            cap_vld <= (state == ACCESS) && (op == OP_READ) && en_l[idx];
            cap_idx <= idx;
            if (cap_vld) begin
                q_r[cap_idx*DW +: DW] <= data_from_mem;
            end
        end
    end

    assign q      = q_r;
    assign MReady = ready_r;

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller with a behavioural synchronous-read RAM on the memory port.
module tb_memory_controller;

    localparam int N  = 4;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              MRead, MWrite, MReady, wren;
    logic [N-1:0]      en;
    logic [N*DW-1:0]   addr, data, q;
    logic [DW-1:0]     data_to_mem, addr_mem, data_from_mem;

    logic [DW-1:0]     mem [0:255];
    logic [DW-1:0]     mem_rd;
    logic              poke_vld;
    logic [7:0]        poke_addr;
    logic [DW-1:0]     poke_dat;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    memory_controller #(.N_CORES(N), .DW(DW)) dut (
        .clk(clk), .reset(reset), .MRead(MRead), .MWrite(MWrite), .MReady(MReady),
        .en(en), .addr(addr), .data(data), .q(q),
        .data_to_mem(data_to_mem), .addr_mem(addr_mem),
        .data_from_mem(data_from_mem), .wren(wren)
    );

    always @(posedge clk) begin
        if (poke_vld) mem[poke_addr] <= poke_dat;
        else if (wren) mem[addr_mem[7:0]] <= data_to_mem;
        mem_rd <= mem[addr_mem[7:0]];
    end
    assign data_from_mem = mem_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] pack(input logic [DW-1:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [DW-1:0] qw(input int i);
        return q[i*DW +: DW];
    endfunction

    task automatic poke(input logic [7:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        poke_vld = 1'b1; poke_addr = a; poke_dat = d;
        @(negedge clk);
        poke_vld = 1'b0;
    endtask

    task automatic check_q(input string tag, input logic [DW-1:0] e0, e1, e2, e3);
        check({tag, ".q0"}, 32'(qw(0)), 32'(e0));
        check({tag, ".q1"}, 32'(qw(1)), 32'(e1));
        check({tag, ".q2"}, 32'(qw(2)), 32'(e2));
        check({tag, ".q3"}, 32'(qw(3)), 32'(e3));
    endtask

    // One request pulse, then sample every falling edge until MReady returns (bounded).
    task automatic run_batch(input logic rd, input logic wr, input logic extra,
                             output int busy, output int wrc, output int first_wr, output int last_wr);
        @(negedge clk);
        MRead = rd; MWrite = wr;
        @(negedge clk);
        MRead = 1'b0; MWrite = 1'b0;
        busy = 0; wrc = 0; first_wr = -1; last_wr = -1;
        while (MReady == 1'b0 && busy < 20) begin
            if (wren) begin
                wrc++;
                if (first_wr < 0) first_wr = busy;
                last_wr = busy;
            end
            if (extra && busy == 1) begin
                MRead = 1'b1; MWrite = 1'b1;
            end else begin
                MRead = 1'b0; MWrite = 1'b0;
            end
            busy++;
            @(negedge clk);
        end
        MRead = 1'b0; MWrite = 1'b0;
    endtask

    int busy, wrc, fw, lw;

    initial begin
        reset = 1'b0; MRead = 1'b0; MWrite = 1'b0;
        en = '0; addr = '0; data = '0; poke_vld = 1'b0; poke_addr = '0; poke_dat = '0;

        // Reset and idle state
        repeat (2) @(negedge clk);
        check("rst.MReady", 32'(MReady), 1);
        check("rst.wren", 32'(wren), 0);
        check("rst.q", 32'(q == '0), 1);
        reset = 1'b1;
        @(negedge clk);
        check("idle.MReady", 32'(MReady), 1);
        check("idle.wren", 32'(wren), 0);
        check("idle.addr_mem", 32'(addr_mem), 0);
        check("idle.data_to_mem", 32'(data_to_mem), 0);

        // Partial-mask read batch
        poke(10, 9); poke(11, 20); poke(12, 55); poke(13, 24);
        en = 4'b0110; addr = pack(10, 11, 12, 13); data = pack(1, 2, 3, 4);
        run_batch(1'b1, 1'b0, 1'b0, busy, wrc, fw, lw);
        check("rd1.busy", 32'(busy), 5);
        check("rd1.wren_cnt", 32'(wrc), 0);
        check_q("rd1", 0, 20, 55, 0);

        // Full write batch into cleared locations
        poke(10, 0); poke(11, 0); poke(12, 0); poke(13, 0);
        en = 4'b1111; addr = pack(10, 11, 12, 13); data = pack(9, 20, 55, 24);
        run_batch(1'b0, 1'b1, 1'b0, busy, wrc, fw, lw);
        check("wr1.busy", 32'(busy), 5);
        check("wr1.wren_cnt", 32'(wrc), 4);
        check("wr1.wren_span", 32'(lw - fw), 3);
        check("wr1.mem10", 32'(mem[10]), 9);
        check("wr1.mem11", 32'(mem[11]), 20);
        check("wr1.mem12", 32'(mem[12]), 55);
        check("wr1.mem13", 32'(mem[13]), 24);
        check_q("wr1", 0, 20, 55, 0);

        run_batch(1'b1, 1'b0, 1'b0, busy, wrc, fw, lw);
        check("rd2.busy", 32'(busy), 5);
        check_q("rd2", 9, 20, 55, 24);

        // Simultaneous read+write is a write; a mid-batch request is dropped
        poke(20, 0); poke(21, 0); poke(22, 0); poke(23, 0);
        addr = pack(20, 21, 22, 23); data = pack(100, 101, 102, 103);
        run_batch(1'b1, 1'b1, 1'b1, busy, wrc, fw, lw);
        check("both.busy", 32'(busy), 5);
        check("both.wren_cnt", 32'(wrc), 4);
        check("both.mem20", 32'(mem[20]), 100);
        check("both.mem23", 32'(mem[23]), 103);
        check_q("both", 9, 20, 55, 24);
        @(negedge clk);
        check("both.no_queue_ready", 32'(MReady), 1);
        check("both.no_queue_wren", 32'(wren), 0);

        // Empty mask still takes the full sequence
        en = 4'b0000; addr = pack(20, 21, 22, 23);
        run_batch(1'b1, 1'b0, 1'b0, busy, wrc, fw, lw);
        check("en0.busy", 32'(busy), 5);
        check_q("en0", 9, 20, 55, 24);

        // Reset during the second ACCESS slot of a write batch
        poke(30, 0); poke(31, 0); poke(32, 0); poke(33, 0);
        en = 4'b1111; addr = pack(30, 31, 32, 33); data = pack(7, 8, 9, 10);
        @(negedge clk);
        MWrite = 1'b1;
        @(negedge clk);
        MWrite = 1'b0;
        check("abort.slot0_wren", 32'(wren), 1);
        @(negedge clk);
        check("abort.slot1_wren", 32'(wren), 1);
        reset = 1'b0;
        #1;
        check("abort.wren_now", 32'(wren), 0);
        check("abort.ready_now", 32'(MReady), 1);
        check("abort.addr_mem", 32'(addr_mem), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort.ready_after", 32'(MReady), 1);
        check("abort.wren_after", 32'(wren), 0);
        check("abort.mem30", 32'(mem[30]), 7);
        check("abort.mem31", 32'(mem[31]), 0);
        check("abort.mem32", 32'(mem[32]), 0);
        check("abort.mem33", 32'(mem[33]), 0);
        check_q("abort", 0, 0, 0, 0);

        // Controller restarts cleanly after the abort
        en = 4'b0001; addr = pack(30, 31, 32, 33);
        run_batch(1'b1, 1'b0, 1'b0, busy, wrc, fw, lw);
        check("post.busy", 32'(busy), 5);
        check_q("post", 7, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/memory_controller.md
MEMORY_CONTROLLER -- requirements
Module: memory_controller

Interface
REQ-001 The module SHALL have parameter N_CORES, default 4, number of cores sharing one data-memory port.
REQ-002 The module SHALL have parameter DW, default 16, data and address width.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 The module SHALL have port MRead, input, 1 bit, batch read request, sampled only in IDLE.
REQ-006 The module SHALL have port MWrite, input, 1 bit, batch write request, sampled only in IDLE.
REQ-007 The module SHALL have port MReady, output, 1 bit, high when idle, low while a batch is in progress.
REQ-008 The module SHALL have port en, input, N_CORES bits, per-core participation mask; bit i is core i.
REQ-009 The module SHALL have port addr, input, N_CORES*DW bits, flattened per-core addresses; core i at [DW*i+DW-1 : DW*i].
REQ-010 The module SHALL have port data, input, N_CORES*DW bits, flattened per-core write data, same packing as addr.
REQ-011 The module SHALL have port q, output, N_CORES*DW bits, flattened per-core registered read results, same packing as addr.
REQ-012 The module SHALL have port data_to_mem, output, DW bits, write data to the memory.
REQ-013 The module SHALL have port addr_mem, output, DW bits, address to the memory.
REQ-014 The module SHALL have port data_from_mem, input, DW bits, memory read data, valid one cycle after its address was presented (synchronous-read RAM).
REQ-015 The module SHALL have port wren, output, 1 bit, memory write enable; the memory writes data_to_mem to addr_mem on the rising edge when wren=1.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS and FINISH, plus an index register idx of width ceil(log2(N_CORES)) or more.
REQ-017 In IDLE: MReady=1, wren=0, addr_mem=0, data_to_mem=0.
REQ-018 At a rising edge in IDLE with MRead=1 or MWrite=1, the module SHALL latch op (write if MWrite=1, else read), latch en into en_l, set idx=0, enter ACCESS, and drive MReady=0 from that edge.
REQ-019 MWrite SHALL take priority when MRead and MWrite are both high; the batch is a write.
REQ-020 In ACCESS, addr_mem=addr[idx], data_to_mem=data[idx], and wren=(op==write)&en_l[idx], all decoded from registered state.
REQ-021 Each ACCESS cycle SHALL last exactly one clock: idx increments by 1; from idx=N_CORES-1 the FSM enters FINISH. Disabled cores still consume their slot, which keeps latency fixed.
REQ-022 For a read batch, when ACCESS idx=k occurs in cycle t and en_l[k]=1, q[k] SHALL load data_from_mem at the end of cycle t+1 via a one-stage capture pipeline (valid, index).
REQ-023 FINISH SHALL last one cycle (capturing the last read, wren=0), then return to IDLE with MReady=1.
REQ-024 Total busy time SHALL be N_CORES+1 cycles from the request edge; MReady is low for exactly that many cycles (5 for N_CORES=4).
REQ-025 q[i] SHALL hold its value for disabled cores, during write batches, and between batches.
REQ-026 MRead/MWrite asserted while not in IDLE SHALL be ignored, not queued.
REQ-027 en is latched; addr and data are sampled live during the corresponding ACCESS slot, so cores SHALL hold them stable until MReady=1.
REQ-028 A request with en=0 SHALL still run the full N_CORES+1-cycle sequence with no writes and no q updates.

Reset
REQ-029 On reset=0, asynchronously: state=IDLE, idx=0, op=read, en_l=0, capture pipeline invalid, every q[i]=0, MReady=1, wren=0.
REQ-030 Reset asserted mid-batch SHALL abort it immediately: wren drops to 0 at once, no further q updates, and the FSM restarts in IDLE after release.

Verification
REQ-031 Reset then idle -> MReady=1, wren=0, all q=0.
REQ-032 mem[10..13]=9,20,55,24 preset; en=0110, addr=10,11,12,13; MRead 1-cycle pulse -> MReady low 5 cycles; q[1]=20, q[2]=55; q[0], q[3] unchanged; wren never 1.
REQ-033 en=1111, data=9,20,55,24, addr=10..13; MWrite 1-cycle pulse -> wren high in 4 consecutive cycles; mem[10..13]=9,20,55,24; q unchanged; a subsequent read batch returns these values.
REQ-034 MRead and MWrite high together -> write batch; a second request pulse during busy -> ignored, MReady returns high after exactly 5 cycles.
REQ-035 reset=0 during the 2nd ACCESS cycle of a write batch -> wren=0 immediately, only mem[addr[0]] written, MReady=1, state IDLE after release.
